// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button gesture logic: event codes delivered on
// evt_code, the gesture FSM state encoding, and a small constant helper used
// to size the millisecond counter.
// ---------------------------------------------------------------------------
package btn_pkg;

    // Event codes presented on evt_code
    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    // Gesture FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
// Free-running prescaler producing a one-cycle tick every CLK_FREQ_KHZ clock
// cycles (one tick per millisecond). Shared with the button debouncer.
//
// Ports
//   clk   in   clock
//   rst   in   asynchronous, active-high reset (counter restarts at 0)
//   tick  out  1 for one cycle when the counter wraps
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int CLK_FREQ_KHZ = 95000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW      = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_FREQ_KHZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
// Turns a debounced, clk-synchronous button level into gesture events:
// SHORT, DOUBLE, LONG and auto-REPEAT while held. Events leave through a
// one-entry valid/ready output register; an event that arrives while the
// register is full and not being accepted is dropped and sets a sticky
// overflow flag.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   btn_level  in   debounced button level, 1 = pressed
//   evt_valid  out  event present on evt_code
//   evt_code   out  0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT
//   evt_ready  in   consumer accepts when evt_valid && evt_ready
//   overflow   out  sticky, an event was dropped (cleared by rst only)
//   held       out  1 while the FSM is in the LONG state
// ---------------------------------------------------------------------------
module button_event #(
    parameter int CLK_FREQ_KHZ = 95000,
    parameter int LONG_MS      = 1000,
    parameter int DCLICK_MS    = 300,
    parameter int REPEAT_MS    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       overflow,
    output logic       held
);

    import btn_pkg::*;

    localparam int               MAX_MS  = max3(LONG_MS, DCLICK_MS, REPEAT_MS);
    localparam int               MS_W    = $clog2(MAX_MS + 1);
    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MAX_MS);
    // A threshold of N ms is reached on the tick that takes ms_cnt from N-1
    // to N, so the decision lands on the tick edge itself. This keeps the
    // repeat period exactly REPEAT_MS ticks after each clear.
    localparam logic [MS_W-1:0]  LONG_M1 = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  DCLK_M1 = MS_W'(DCLICK_MS - 1);
    localparam logic [MS_W-1:0]  RPT_M1  = MS_W'(REPEAT_MS - 1);

    logic            tick;
    logic [2:0]      state_q, state_d;
    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic            evt_valid_q, evt_valid_d;
    logic [1:0]      evt_code_q, evt_code_d;
    logic            overflow_q, overflow_d;

    logic            long_hit, dclk_hit, rpt_hit;
    logic            new_evt;
    logic [1:0]      new_code;
    logic            rpt_clr;
    logic            accept;

    ms_tick_gen #(
        .CLK_FREQ_KHZ (CLK_FREQ_KHZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign long_hit = tick && (ms_cnt_q == LONG_M1);
    assign dclk_hit = tick && (ms_cnt_q == DCLK_M1);
    assign rpt_hit  = tick && (ms_cnt_q == RPT_M1);

    // Gesture FSM. Every branch tests btn_level first so that a level change
    // wins over a threshold reached in the same cycle.
    always_comb begin
        state_d  = state_q;
        new_evt  = 1'b0;
        new_code = EVT_SHORT;
        rpt_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_level) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!btn_level) begin
                    state_d = ST_WAIT2;
                end else if (long_hit) begin
                    state_d  = ST_LONG;
                    new_evt  = 1'b1;
                    new_code = EVT_LONG;
                end
            end
            ST_WAIT2: begin
                if (btn_level) begin
                    state_d = ST_PRESS2;
                end else if (dclk_hit) begin
                    state_d  = ST_IDLE;
                    new_evt  = 1'b1;
                    new_code = EVT_SHORT;
                end
            end
            ST_PRESS2: begin
                if (!btn_level) begin
                    state_d  = ST_IDLE;
                    new_evt  = 1'b1;
                    new_code = EVT_DOUBLE;
                end
            end
            ST_LONG: begin
                if (!btn_level) begin
                    state_d = ST_IDLE;
                end else if (rpt_hit) begin
                    new_evt  = 1'b1;
                    new_code = EVT_REPEAT;
                    rpt_clr  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Millisecond counter: restarts on any state change or repeat, otherwise
    // counts ticks and saturates.
    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if ((state_d != state_q) || rpt_clr) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != MS_MAX)) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
        end
    end

    // One-entry output register with drop-on-full and sticky overflow.
    assign accept = evt_valid_q && evt_ready;

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        overflow_d  = overflow_q;
        if (new_evt) begin
            if (!evt_valid_q || accept) begin
                evt_valid_d = 1'b1;
                evt_code_d  = new_code;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ms_cnt_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_SHORT;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ms_cnt_q    <= ms_cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign overflow  = overflow_q;
    assign held      = (state_q == ST_LONG);

endmodule

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
// Directed bench for button_event with CLK_FREQ_KHZ=10, LONG_MS=20,
// DCLICK_MS=8, REPEAT_MS=5. Inputs change 1 time unit after a rising edge;
// accepted events are logged on the falling edge with the edge count of the
// cycle in which they appeared.
// ---------------------------------------------------------------------------
module tb_button_event;

    localparam int CLK_FREQ_KHZ = 10;
    localparam int LONG_MS      = 20;
    localparam int DCLICK_MS    = 8;
    localparam int REPEAT_MS    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_level;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       overflow;
    logic       held;

    button_event #(
        .CLK_FREQ_KHZ (CLK_FREQ_KHZ),
        .LONG_MS      (LONG_MS),
        .DCLICK_MS    (DCLICK_MS),
        .REPEAT_MS    (REPEAT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .held      (held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        int         t;
        logic       hld;
    } ev_t;

    ev_t evq[$];

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            evq.push_back('{code: evt_code, t: cyc, hld: held});
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int c0;
        int lat;
        int phase;
        int e0;
        int t1;
        int t20;

        rst       = 1'b0;
        btn_level = 1'b0;
        evt_ready = 1'b1;
        phase     = 0;
        #1 rst = 1'b1;
        step(3);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_code",  evt_code,  0);
        check("rst_overflow",  overflow,  0);
        check("rst_held",      held,      0);
        rst = 1'b0;
        step(5);

        // Short press: one SHORT once the double-click window expires
        evq.delete();
        btn_level = 1'b1;
        step(50);
        btn_level = 1'b0;
        c = cyc;
        step(120);
        check("short_count", evq.size(), 1);
        if (evq.size() != 0) begin
            lat = evq[0].t - c;
            check("short_code", evq[0].code, 0);
            check($sformatf("short_lat(%0d)_in_71_81", lat), (lat >= 71 && lat <= 81), 1);
        end

        // Double click: DOUBLE one cycle after the second release, no SHORT
        evq.delete();
        btn_level = 1'b1;
        step(50);
        btn_level = 1'b0;
        step(30);
        btn_level = 1'b1;
        step(50);
        btn_level = 1'b0;
        c = cyc;
        step(100);
        check("double_count", evq.size(), 1);
        if (evq.size() != 0) begin
            check("double_code", evq[0].code, 1);
            check("double_lat",  evq[0].t - c, 1);
        end

        // Long hold: LONG then four REPEATs 50 cycles apart, nothing on release
        evq.delete();
        btn_level = 1'b1;
        c0 = cyc;
        step(100);
        check("held_before_long", held, 0);
        step(305);
        check("held_before_release", held, 1);
        btn_level = 1'b0;
        step(1);
        check("held_after_release", held, 0);
        step(60);
        check("long_count", evq.size(), 5);
        if (evq.size() == 5) begin
            lat = evq[0].t - c0;
            // 20 ms quantized to 191..200 cycles, plus the output register
            check("long_code", evq[0].code, 2);
            check($sformatf("long_lat(%0d)_in_191_201", lat), (lat >= 191 && lat <= 201), 1);
            check("held_with_long", evq[0].hld, 1);
            for (int k = 1; k < 5; k++) begin
                check($sformatf("repeat%0d_code", k), evq[k].code, 3);
                check($sformatf("repeat%0d_gap", k), evq[k].t - evq[k-1].t, 50);
            end
            phase = evq[0].t % CLK_FREQ_KHZ;
        end

        // Release on the very tick that would complete LONG_MS: SHORT, no LONG.
        // The LONG edge above lies on a tick edge, which fixes the tick phase.
        evq.delete();
        btn_level = 1'b1;
        c0 = cyc;
        e0 = c0 + 1;
        t1 = e0 + 1 + ((phase - ((e0 + 1) % CLK_FREQ_KHZ) + CLK_FREQ_KHZ) % CLK_FREQ_KHZ);
        t20 = t1 + (LONG_MS - 1) * CLK_FREQ_KHZ;
        step(t20 - 1 - c0);
        btn_level = 1'b0;
        c = cyc;
        step(120);
        check("edge_release_count", evq.size(), 1);
        if (evq.size() != 0) begin
            lat = evq[0].t - c;
            check("edge_release_code", evq[0].code, 0);
            check($sformatf("edge_release_lat(%0d)_in_71_81", lat), (lat >= 71 && lat <= 81), 1);
        end

        // Consumer stalled: first event held stable, second dropped
        evq.delete();
        evt_ready = 1'b0;
        btn_level = 1'b1;
        step(50);
        btn_level = 1'b0;
        step(100);
        check("stall_valid",    evt_valid, 1);
        check("stall_code",     evt_code,  0);
        check("stall_overflow", overflow,  0);
        step(5);
        check("stall_code_stable", evt_code, 0);
        btn_level = 1'b1;
        step(220);
        btn_level = 1'b0;
        step(20);
        check("drop_valid",    evt_valid, 1);
        check("drop_code",     evt_code,  0);
        check("drop_overflow", overflow,  1);
        check("drop_none_accepted", evq.size(), 0);
        evt_ready = 1'b1;
        step(1);
        check("drain_valid",    evt_valid, 0);
        check("drain_overflow", overflow,  1);
        check("drain_count",    evq.size(), 1);
        if (evq.size() != 0) begin
            check("drain_code", evq[0].code, 0);
        end

        // Reset in the middle of a hold: immediate clear, gesture forgotten
        evq.delete();
        btn_level = 1'b1;
        step(100);
        rst = 1'b1;
        #1;
        check("async_rst_valid",    evt_valid, 0);
        check("async_rst_code",     evt_code,  0);
        check("async_rst_overflow", overflow,  0);
        check("async_rst_held",     held,      0);
        btn_level = 1'b0;
        step(2);
        rst = 1'b0;
        step(150);
        check("post_rst_events",   evq.size(), 0);
        check("post_rst_held",     held,       0);
        check("post_rst_overflow", overflow,   0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
